// File: rtl/cube_pkg.sv
// Shared constants, controller state type and the 32-bit vertex entry layout
// used by the cube overlay and its producers.
package cube_pkg;

   localparam int unsigned CORD_SIZE = 11;
   localparam int unsigned MAX_X     = 1226;
   localparam int unsigned MAX_Y     = 370;

   typedef enum logic {
      COLLECT = 1'b0,
      PENDING = 1'b1
   } cube_ctrl_state_t;

   // Entry layout: x in [CORD_SIZE-1:0], y in [16+CORD_SIZE-1:16], rest zero.
   function automatic logic [31:0] pack_pt(input logic [CORD_SIZE-1:0] x,
                                           input logic [CORD_SIZE-1:0] y);
      logic [31:0] e;
      e                 = '0;
      e[CORD_SIZE-1:0]  = x;
      e[16 +: CORD_SIZE] = y;
      return e;
   endfunction

endpackage

// File: rtl/cube_pts_ctrl_if.sv
// Vertex beat valid/ready channel from the pose/projection pipeline.
interface cube_pts_ctrl_if import cube_pkg::*; ();

   logic                 pt_valid;
   logic                 pt_ready;
   logic [2:0]           pt_idx;
   logic [CORD_SIZE-1:0] pt_x;
   logic [CORD_SIZE-1:0] pt_y;
   logic                 pt_last;

   modport master (
      output pt_valid, pt_idx, pt_x, pt_y, pt_last,
      input  pt_ready
   );

   modport slave (
      input  pt_valid, pt_idx, pt_x, pt_y, pt_last,
      output pt_ready
   );

endinterface

// File: rtl/sync_edge_detect.sv
// One-cycle register of a level plus rising-edge detect; the reset value sets
// whether a level already high at reset release counts as an edge.
module sync_edge_detect #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic rise
);

   logic din_q;

   always_ff @(posedge clk) begin
      if (rst) din_q <= RST_VAL;
      else     din_q <= din;
   end

   assign rise = din & ~din_q;

endmodule

// File: rtl/cube_pts_ctrl.sv
// Collects 8 projected vertices into a shadow table and commits the complete
// set to the overlay only at a frame start; blanks the overlay when updates stop.
module cube_pts_ctrl import cube_pkg::*; #(
   parameter int unsigned STALE_FRAMES = 30
) (
   input  logic             clk,
   input  logic             rst,
   cube_pts_ctrl_if.slave   pt,
   input  logic             vsync_in,
   output logic [7:0][31:0] cube_pts,
   output logic             overlay_en,
   output logic             commit_pulse,
   output logic [15:0]      drop_cnt
);

   localparam int unsigned          SW        = $clog2(STALE_FRAMES + 1);
   localparam logic [SW-1:0]        STALE_MAX = SW'(STALE_FRAMES);
   localparam logic [CORD_SIZE-1:0] X_LIM     = CORD_SIZE'(MAX_X - 1);
   localparam logic [CORD_SIZE-1:0] Y_LIM     = CORD_SIZE'(MAX_Y - 1);

   cube_ctrl_state_t            state_q, state_d;
   logic [7:0]                  mask_q, mask_d;
   logic [7:0][CORD_SIZE-1:0]   shadow_x_q, shadow_x_d, shadow_y_q, shadow_y_d;
   logic [7:0][CORD_SIZE-1:0]   active_x_q, active_x_d, active_y_q, active_y_d;
   logic [SW-1:0]               stale_q, stale_d;
   logic                        overlay_q, overlay_d;
   logic                        commit_q, commit_d;
   logic [15:0]                 drop_q, drop_d;

   logic                        frame_start;
   logic                        accept;
   logic [7:0]                  idx_bit;
   logic [CORD_SIZE-1:0]        x_clamp, y_clamp;

   // Reset value 1: a vsync already high at reset release is not a frame start.
   sync_edge_detect #(
      .RST_VAL (1'b1)
   ) u_vs_edge (
      .clk  (clk),
      .rst  (rst),
      .din  (vsync_in),
      .rise (frame_start)
   );

   assign pt.pt_ready = (state_q == COLLECT) && !rst;
   assign accept      = pt.pt_valid && pt.pt_ready;
   assign idx_bit     = 8'(1) << pt.pt_idx;
   assign x_clamp     = (pt.pt_x > X_LIM) ? X_LIM : pt.pt_x;
   assign y_clamp     = (pt.pt_y > Y_LIM) ? Y_LIM : pt.pt_y;

   always_comb begin
      state_d    = state_q;
      mask_d     = mask_q;
      shadow_x_d = shadow_x_q;
      shadow_y_d = shadow_y_q;
      active_x_d = active_x_q;
      active_y_d = active_y_q;
      stale_d    = stale_q;
      overlay_d  = overlay_q;
      commit_d   = 1'b0;
      drop_d     = drop_q;
      case (state_q)
         COLLECT: begin
            if (accept) begin
               shadow_x_d[pt.pt_idx] = x_clamp;
               shadow_y_d[pt.pt_idx] = y_clamp;
               mask_d                = mask_q | idx_bit;
               if (pt.pt_last) begin
                  if ((mask_q | idx_bit) == 8'hFF) begin
                     state_d = PENDING;
                  end else begin
                     mask_d = '0;
                     if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
                  end
               end
            end
            // A frame start in COLLECT counts as stale even if this beat completes the set.
            if (frame_start && (stale_q != STALE_MAX)) begin
               stale_d = stale_q + SW'(1);
               if (stale_d == STALE_MAX) overlay_d = 1'b0;
            end
         end
         PENDING: begin
            if (frame_start) begin
               active_x_d = shadow_x_q;
               active_y_d = shadow_y_q;
               commit_d   = 1'b1;
               overlay_d  = 1'b1;
               stale_d    = '0;
               mask_d     = '0;
               state_d    = COLLECT;
            end
         end
         default: state_d = COLLECT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= COLLECT;
         mask_q     <= '0;
         shadow_x_q <= '0;
         shadow_y_q <= '0;
         active_x_q <= '0;
         active_y_q <= '0;
         stale_q    <= '0;
         overlay_q  <= 1'b0;
         commit_q   <= 1'b0;
         drop_q     <= '0;
      end else begin
         state_q    <= state_d;
         mask_q     <= mask_d;
         shadow_x_q <= shadow_x_d;
         shadow_y_q <= shadow_y_d;
         active_x_q <= active_x_d;
         active_y_q <= active_y_d;
         stale_q    <= stale_d;
         overlay_q  <= overlay_d;
         commit_q   <= commit_d;
         drop_q     <= drop_d;
      end
   end

   always_comb begin
      for (int i = 0; i < 8; i++) cube_pts[i] = pack_pt(active_x_q[i], active_y_q[i]);
   end

   assign overlay_en   = overlay_q;
   assign commit_pulse = commit_q;
   assign drop_cnt     = drop_q;

endmodule

// File: tb/tb_cube_pts_ctrl.sv
// Directed bench for cube_pts_ctrl: an abstract frame/set model checked against the
// DUT every cycle, plus literal expectations pinning key values.
module tb_cube_pts_ctrl;
   import cube_pkg::*;

   localparam int STALE = 30;

   logic             clk = 1'b0;
   logic             rst;
   logic             vsync_in;
   logic [7:0][31:0] cube_pts;
   logic             overlay_en;
   logic             commit_pulse;
   logic [15:0]      drop_cnt;

   cube_pts_ctrl_if pt_if ();

   cube_pts_ctrl #(
      .STALE_FRAMES (STALE)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .pt           (pt_if),
      .vsync_in     (vsync_in),
      .cube_pts     (cube_pts),
      .overlay_en   (overlay_en),
      .commit_pulse (commit_pulse),
      .drop_cnt     (drop_cnt)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;
   bit chk_en = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: a set is "pending" once every index has been seen before a last beat.
   int          m_sx[8], m_sy[8];
   bit          m_seen[8];
   bit          m_pending, m_en, m_commit, m_vs_prev, m_full, m_fs;
   int          m_stale, m_drops;
   logic [31:0] m_active[8];

   function automatic int clampv(input int v, input int lim);
      return (v > lim - 1) ? lim - 1 : v;
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         m_pending = 0; m_en = 0; m_commit = 0; m_stale = 0; m_drops = 0;
         for (int i = 0; i < 8; i++) begin
            m_seen[i] = 0; m_active[i] = 32'd0; m_sx[i] = 0; m_sy[i] = 0;
         end
         m_vs_prev = 1;
      end else begin
         m_fs     = vsync_in && !m_vs_prev;
         m_commit = 0;
         if (m_pending) begin
            if (m_fs) begin
               for (int i = 0; i < 8; i++) m_active[i] = 32'(m_sy[i] * 65536 + m_sx[i]);
               m_commit = 1; m_en = 1; m_stale = 0; m_pending = 0;
            end
         end else begin
            if (pt_if.pt_valid) begin
               m_sx[pt_if.pt_idx]   = clampv(int'(pt_if.pt_x), MAX_X);
               m_sy[pt_if.pt_idx]   = clampv(int'(pt_if.pt_y), MAX_Y);
               m_seen[pt_if.pt_idx] = 1;
               if (pt_if.pt_last) begin
                  m_full = 1;
                  for (int i = 0; i < 8; i++) if (!m_seen[i]) m_full = 0;
                  if (m_full) m_pending = 1;
                  else if (m_drops < 65535) m_drops++;
                  for (int i = 0; i < 8; i++) m_seen[i] = 0;
               end
            end
            if (m_fs && m_stale < STALE) begin
               m_stale++;
               if (m_stale == STALE) m_en = 0;
            end
         end
         m_vs_prev = vsync_in;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("pt_ready", 64'(pt_if.pt_ready), 64'(!rst && !m_pending));
         check("overlay_en", 64'(overlay_en), 64'(m_en));
         check("commit_pulse", 64'(commit_pulse), 64'(m_commit));
         check("drop_cnt", 64'(drop_cnt), 64'(m_drops));
         for (int i = 0; i < 8; i++) check("cube_pts", 64'(cube_pts[i]), 64'(m_active[i]));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic beat(input int idx, input int x, input int y, input bit last);
      pt_if.pt_valid = 1'b1;
      pt_if.pt_idx   = 3'(idx);
      pt_if.pt_x     = CORD_SIZE'(x);
      pt_if.pt_y     = CORD_SIZE'(y);
      pt_if.pt_last  = last;
      tick();
      pt_if.pt_valid = 1'b0;
      pt_if.pt_last  = 1'b0;
   endtask

   task automatic vs_rise();
      vsync_in = 1'b1;
      tick();
      vsync_in = 1'b0;
      tick();
   endtask

   logic [31:0] saved3;

   initial begin
      rst = 1'b1; vsync_in = 1'b1;
      pt_if.pt_valid = 1'b0; pt_if.pt_idx = '0; pt_if.pt_x = '0; pt_if.pt_y = '0;
      pt_if.pt_last = 1'b0;
      tick();
      chk_en = 1'b1;
      tick(); tick();
      check("ready_in_reset", 64'(pt_if.pt_ready), 64'd0);
      rst = 1'b0;
      #1;
      check("ready_after_reset", 64'(pt_if.pt_ready), 64'd1);
      tick(); tick();
      check("no_commit_vs_high", 64'(commit_pulse), 64'd0);
      check("overlay_off_reset", 64'(overlay_en), 64'd0);
      vsync_in = 1'b0;
      tick();

      // Basic full set then commit.
      for (int i = 0; i < 8; i++) beat(i, 100 + i, 50 + i, i == 7);
      check("ready_pending", 64'(pt_if.pt_ready), 64'd0);
      vsync_in = 1'b1;
      tick();
      check("cube3_commit", 64'(cube_pts[3]), 64'h0035_0067);
      check("commit_hi", 64'(commit_pulse), 64'd1);
      check("overlay_on", 64'(overlay_en), 64'd1);
      tick();
      check("commit_one_cycle", 64'(commit_pulse), 64'd0);
      vsync_in = 1'b0;
      tick();

      // Incomplete set with a duplicate index is dropped.
      for (int i = 0; i < 7; i++) beat(i, 300 + i, 20 + i, 1'b0);
      beat(6, 333, 33, 1'b1);
      check("drop_cnt_1", 64'(drop_cnt), 64'd1);
      check("ready_after_drop", 64'(pt_if.pt_ready), 64'd1);
      for (int i = 0; i < 8; i++) beat(i, 200 + 3 * i, 10 + i, i == 7);
      vs_rise();

      // Clamping.
      for (int i = 0; i < 8; i++) begin
         if (i == 2) beat(i, 2047, 400, 1'b0);
         else        beat(i, 10 * i, 5 * i, i == 7);
      end
      vs_rise();
      check("cube2_clamp", 64'(cube_pts[2]), 64'h0171_04C9);

      // Completing beat coincides with frame start, then valid held in PENDING.
      for (int i = 0; i < 7; i++) beat(i, 400 + i, 100 + i, 1'b0);
      vsync_in = 1'b1;
      beat(7, 777, 177, 1'b1);
      check("no_commit_same_edge", 64'(commit_pulse), 64'd0);
      pt_if.pt_valid = 1'b1; pt_if.pt_idx = 3'd7; pt_if.pt_x = 11'd5; pt_if.pt_y = 11'd5;
      pt_if.pt_last = 1'b1;
      tick(); tick();
      check("ready_low_pending", 64'(pt_if.pt_ready), 64'd0);
      vsync_in = 1'b0;
      tick();
      vsync_in = 1'b1;
      tick();
      pt_if.pt_valid = 1'b0; pt_if.pt_last = 1'b0;
      check("cube7_no_junk", 64'(cube_pts[7]), 64'h00B1_0309);
      vsync_in = 1'b0;
      tick();

      // Commit wins over reaching the stale limit, then go stale.
      for (int k = 0; k < STALE - 1; k++) vs_rise();
      check("overlay_29", 64'(overlay_en), 64'd1);
      for (int i = 0; i < 8; i++) beat(i, 600 + i, 60 + i, i == 7);
      vs_rise();
      check("overlay_commit_wins", 64'(overlay_en), 64'd1);
      saved3 = 32'((60 + 3) * 65536 + 600 + 3);
      for (int k = 0; k < STALE - 1; k++) vs_rise();
      check("overlay_before_30", 64'(overlay_en), 64'd1);
      vsync_in = 1'b1;
      tick();
      check("overlay_stale", 64'(overlay_en), 64'd0);
      check("cube3_held", 64'(cube_pts[3]), 64'(saved3));
      vsync_in = 1'b0;
      tick();

      // Reset while PENDING.
      for (int i = 0; i < 8; i++) beat(i, 900 + i, 90 + i, i == 7);
      rst = 1'b1;
      tick();
      check("rst_cube0", 64'(cube_pts[0]), 64'd0);
      check("rst_drop", 64'(drop_cnt), 64'd0);
      check("rst_ready", 64'(pt_if.pt_ready), 64'd0);
      rst = 1'b0;
      tick();
      vs_rise();
      check("no_commit_after_rst", 64'(overlay_en), 64'd0);
      tick();

      chk_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/cube_pts_ctrl.md
# cube_pts_ctrl

Frame-synchronous controller for the cube-overlay vertex table. It collects projected vertex coordinates from the pose/projection pipeline over a valid/ready handshake into a shadow table. It commits a complete 8-vertex set to the overlay's `cube_pts` input only at a frame start (vsync rising edge), so the overlay never draws a half-updated cube. It also blanks the overlay when updates stop arriving.

## Interface
Parameters:
- `CORD_SIZE`, 11: coordinate width in bits.
- `MAX_X`, 1226: active width in pixels; x is clamped to `MAX_X-1`.
- `MAX_Y`, 370: active height in lines; y is clamped to `MAX_Y-1`.
- `STALE_FRAMES`, 30: number of frame starts without a commit before the overlay is disabled.

Ports:
- `clk` in 1: single clock, same domain as the pixel stream.
- `rst` in 1: synchronous, active-high reset.
- `pt_valid` in 1: vertex beat valid.
- `pt_ready` out 1: vertex beat accepted when high together with `pt_valid`.
- `pt_idx` in 3: vertex index 0..7.
- `pt_x` in `CORD_SIZE`: unsigned x coordinate.
- `pt_y` in `CORD_SIZE`: unsigned y coordinate.
- `pt_last` in 1: marks the final beat of a vertex set.
- `vsync_in` in 1: active-high vsync from the video timing path.
- `cube_pts` out 8×32: active table; entry i holds x in bits [CORD_SIZE-1:0] and y in bits [16+CORD_SIZE-1:16]; all other bits are 0.
- `overlay_en` out 1: high while the active table is fresh; drives the overlay bypass mux.
- `commit_pulse` out 1: one-cycle strobe when the active table is updated.
- `drop_cnt` out 16: saturating count of discarded incomplete sets.

## Operation
- Two states: COLLECT and PENDING.
- `pt_ready` = (state==COLLECT) && !rst. It has no registered delay.
- COLLECT, on an accepted beat:
  - Clamp x and y to the limits above.
  - Write `shadow[pt_idx]`.
  - Set `mask[pt_idx]`.
  - A duplicate index in the same set overwrites the earlier value; this is legal.
- COLLECT, accepted beat with `pt_last`:
  - If (mask | 1<<pt_idx) == 8'hFF: go to PENDING.
  - Otherwise: clear the mask, increment `drop_cnt` (saturating at 16'hFFFF), and stay in COLLECT. Shadow contents are left as-is.
- Frame start is a rising edge of `vsync_in`: vsync_in=1 while vs_q=0, where vs_q is `vsync_in` registered one cycle.
- PENDING, on frame start:
  - Copy shadow to `cube_pts`.
  - Pulse `commit_pulse`.
  - Set `overlay_en`=1.
  - Clear the stale counter and the mask.
  - Return to COLLECT.
- COLLECT, on frame start: no commit; the stale counter increments.
- Stale counter:
  - Saturates at `STALE_FRAMES`.
  - When an increment reaches `STALE_FRAMES`, `overlay_en` goes to 0.
  - `cube_pts` holds its last value while stale.
- Simultaneous events:
  - A completing `pt_last` beat in the same cycle as a frame start: enter PENDING and count the edge as stale. The commit happens on the next frame start, never in the same cycle.
  - A frame start in PENDING in the same cycle that the stale counter would reach the limit: the commit wins, `overlay_en` stays 1, and the counter is cleared.

## Timing
- Reset values: `cube_pts`=0, `overlay_en`=0, `commit_pulse`=0, `drop_cnt`=0, state=COLLECT, mask=0, stale counter=0, vs_q=1 (a vsync already high at reset release is not a frame start), `pt_ready`=0 while `rst` is high.
- Reset asserted mid-set or in PENDING: the partial or pending set is discarded and all registers return to their reset values on the next edge.
- Frame start sampled at edge N: `cube_pts`, `overlay_en` and `commit_pulse` change at edge N+1, and `commit_pulse` is high for exactly that one cycle.
- `pt_ready` drops in the cycle after a completing `pt_last` is accepted and rises again in the cycle after the commit.
- Throughput: one beat per cycle in COLLECT. A full set takes a minimum of 8 cycles.
- Overlay disable: `overlay_en` falls one cycle after the `STALE_FRAMES`-th consecutive frame start without a commit.

## Structure
- Package `cube_pkg`:
  - `CORD_SIZE`, `MAX_X`, `MAX_Y`.
  - State enum `cube_ctrl_state_t` {COLLECT, PENDING}.
  - Function `pack_pt(x, y)` returning the 32-bit entry layout. The overlay and any future cube consumers share this layout.
- Sub-module `sync_edge_detect`: register plus rising-edge detect, with a parameterised reset value. It is reusable for hsync and vde.
- Storage: the shadow and active tables are plain registers (8×2×`CORD_SIZE` bits each); no RAM.

## Test plan
- Reset release with `vsync_in`=1 held high -> no `commit_pulse`, `overlay_en`=0, `pt_ready`=1 from the first post-reset cycle.
- Indices 0..7 written with x=100+i and y=50+i, `pt_last` on idx 7, then a vsync rise -> `cube_pts[3]`=32'h0035_0067 one cycle after the edge, `commit_pulse` high for exactly 1 cycle, `overlay_en`=1.
- Set containing idx 0..6 plus a duplicate 6 with `pt_last` -> `drop_cnt`=1, no state change; the next full set commits normally.
- Vertex with x=2047, y=400 -> entry holds x=1225, y=369.
- Completing `pt_last` in the same cycle as a vsync rise -> no commit on that edge; commit on the following rise. `pt_valid` held high in PENDING -> `pt_ready`=0 and no shadow writes.
- After one commit, 30 vsync rises with no new sets -> `overlay_en` falls one cycle after the 30th edge while `cube_pts` keeps its value; assert `rst` while in PENDING -> all outputs return to reset values.
